// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one line-granular main_mem port between two cache requesters
//   (port 0 = D-cache, port 1 = I-cache). A request seen in IDLE is latched
//   (op, address, write line), replayed to main_mem from the latched copy while
//   BUSY, and the main_mem grant is routed back to the owning port together
//   with a registered copy of the read line. Ties are broken round-robin.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   pK_rd_req / pK_wr_req         port K line read / write request (held until gnt)
//   pK_addr                       port K line address
//   pK_wr_line                    port K write line
//   pK_rd_line                    port K registered read line
//   pK_gnt                        port K transaction done, 1-cycle pulse
//   mem_rd_req / mem_wr_req       request to main_mem
//   mem_addr / mem_wr_line        address / write data to main_mem
//   mem_rd_line / mem_gnt         read data / grant from main_mem
//   p0_grant_cnt / p1_grant_cnt   completed transactions per port (wrapping)
module mem_port_arbiter #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  p0_rd_req,
    input  logic                                  p0_wr_req,
    input  logic [ADDR_LEN-1:0]                   p0_addr,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]      p0_wr_line,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]      p0_rd_line,
    output logic                                  p0_gnt,
    input  logic                                  p1_rd_req,
    input  logic                                  p1_wr_req,
    input  logic [ADDR_LEN-1:0]                   p1_addr,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]      p1_wr_line,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]      p1_rd_line,
    output logic                                  p1_gnt,
    output logic                                  mem_rd_req,
    output logic                                  mem_wr_req,
    output logic [ADDR_LEN-1:0]                   mem_addr,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]      mem_wr_line,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]      mem_rd_line,
    input  logic                                  mem_gnt,
    output logic [CNT_WIDTH-1:0]                  p0_grant_cnt,
    output logic [CNT_WIDTH-1:0]                  p1_grant_cnt
);

    localparam int LINE_W = 32 * (2 ** LINE_ADDR_LEN);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q;
    logic                last_owner_q;
    logic                owner_q;
    logic                op_wr_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [LINE_W-1:0]   wr_line_q;

    // Per-port views so the datapath below can be generated per port.
    logic [1:0]          req;
    logic [1:0]          wr_sel;
    logic [ADDR_LEN-1:0] addr_in   [2];
    logic [LINE_W-1:0]   line_in   [2];
    logic [LINE_W-1:0]   rd_line_q [2];
    logic [CNT_WIDTH-1:0] cnt_q    [2];
    logic [1:0]          gnt;

    assign req[0]     = p0_rd_req | p0_wr_req;
    assign req[1]     = p1_rd_req | p1_wr_req;
    assign wr_sel[0]  = p0_wr_req;   // write wins when both rd and wr are set
    assign wr_sel[1]  = p1_wr_req;
    assign addr_in[0] = p0_addr;
    assign addr_in[1] = p1_addr;
    assign line_in[0] = p0_wr_line;
    assign line_in[1] = p1_wr_line;

    // Winner: a lone requester wins; on a tie the port that did not own the
    // previous transaction wins.
    logic win_d;
    always_comb begin
        win_d = 1'b0;
        if (req[0] && req[1]) begin
            win_d = ~last_owner_q;
        end else begin
            win_d = req[1];
        end
    end

    logic busy;
    logic done;
    assign busy = (state_q == BUSY);
    assign done = busy & mem_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            op_wr_q      <= 1'b0;
            addr_q       <= '0;
            wr_line_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        owner_q      <= win_d;
                        last_owner_q <= win_d;
                        op_wr_q      <= wr_sel[win_d];
                        addr_q       <= addr_in[win_d];
                        wr_line_q    <= line_in[win_d];
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_gnt) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // main_mem side is driven only from the latched transaction.
    assign mem_rd_req  = busy & ~op_wr_q;
    assign mem_wr_req  = busy & op_wr_q;
    assign mem_addr    = busy ? addr_q : '0;
    assign mem_wr_line = busy ? wr_line_q : '0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign gnt[gi] = done & (owner_q == gi[0]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_line_q[gi] <= '0;
                    cnt_q[gi]     <= '0;
                end else if (gnt[gi]) begin
                    if (!op_wr_q) begin
                        rd_line_q[gi] <= mem_rd_line;
                    end
                    cnt_q[gi] <= cnt_q[gi] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign p0_gnt       = gnt[0];
    assign p1_gnt       = gnt[1];
    assign p0_rd_line   = rd_line_q[0];
    assign p1_rd_line   = rd_line_q[1];
    assign p0_grant_cnt = cnt_q[0];
    assign p1_grant_cnt = cnt_q[1];

endmodule
